tlda_pixel_writer: RTL and testbench

Responder side of the thick-line-drawing pixel handshake. Accepts one pixel request at a time from the line drawer (`Draw`, `Pixel_Address`, `Color`), buffers it, and writes it to the frame buffer through an Avalon-MM write-only master, returning `Write_Finish` to the drawer. Sits between the line-drawing engine and the SDRAM/SRAM frame-buffer interconnect.

---
 rtl/tlda_pixel_writer.sv | 164 ++++++++++++++++
 tb/tb_tlda_pixel_writer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlda_pixel_writer.sv
// tlda_pixel_writer
//   Responder side of the thick-line-drawing pixel handshake. A pixel request
//   (Draw / Pixel_Address / Color) is captured into a request buffer and then
//   written to the frame buffer over an Avalon-MM write-only master.
//   Write_Finish pulses for one cycle per captured request.
//
//   Build option: define TLDA_PW_FIFO_EN to make the request buffer a
//   FIFO_DEPTH-entry circular FIFO. When it is undefined the buffer is a
//   single holding register (depth 1).
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   Draw                 drawer request level, held until Write_Finish
//   Pixel_Address[31:0]  pixel byte address
//   Color[15:0]          RGB565 pixel value
//   Write_Finish         one-cycle pulse: request captured
//   avm_*                Avalon-MM write master (address, write, writedata,
//                        byteenable, waitrequest)
//   Idle                 buffer empty and no write outstanding
//   Pixel_Count[31:0]    completed bus writes since reset (wraps)
module tlda_pixel_writer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        Draw,
    input  logic [31:0] Pixel_Address,
    input  logic [15:0] Color,
    output logic        Write_Finish,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic [15:0] avm_writedata,
    output logic [1:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    output logic        Idle,
    output logic [31:0] Pixel_Count
);

    typedef enum logic {B_IDLE, B_WRITE} bus_state_e;

    bus_state_e  state_q;
    logic [31:0] addr_q, pixel_count_q;
    logic [15:0] data_q;
    logic [1:0]  be_q;
    logic        write_q, wf_q, idle_q;

    logic        push, pop;
    logic        buf_empty, buf_full, buf_many, buf_empty_d;
    logic [47:0] head_w, next_w;
    logic        write_d;

    // Write_Finish masks the capture so a Draw held across the pulse
    // cycle is not sampled twice.
    assign push = Draw && !wf_q && !buf_full;
    assign pop  = (state_q == B_WRITE) && !avm_waitrequest;

`ifdef TLDA_PW_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [AW:0]   wr_ptr_q, rd_ptr_q, occ, occ_d;
    logic [AW-1:0] rd_nxt;
    logic [47:0]   mem_q [FIFO_DEPTH];

    assign occ         = wr_ptr_q - rd_ptr_q;
    assign occ_d       = occ + (AW+1)'(push) - (AW+1)'(pop);
    assign buf_empty   = (occ == '0);
    assign buf_full    = (occ == (AW+1)'(FIFO_DEPTH));
    assign buf_many    = (occ > (AW+1)'(1));
    assign buf_empty_d = (occ_d == '0);
    assign rd_nxt      = rd_ptr_q[AW-1:0] + AW'(1);
    assign head_w      = mem_q[rd_ptr_q[AW-1:0]];
    assign next_w      = mem_q[rd_nxt];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {Pixel_Address, Color};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end
`else
    logic [47:0] hold_q;
    logic        hold_vld_q;

    // push only happens while the register is empty, so push and pop
    // never coincide.
    assign buf_empty   = !hold_vld_q;
    assign buf_full    = hold_vld_q;
    assign buf_many    = 1'b0;
    assign buf_empty_d = !(push || (hold_vld_q && !pop));
    assign head_w      = hold_q;
    assign next_w      = hold_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else if (push) begin
            hold_q     <= {Pixel_Address, Color};
            hold_vld_q <= 1'b1;
        end else if (pop) begin
            hold_vld_q <= 1'b0;
        end
    end
`endif

    // Next value of avm_write; feeds the registered Idle flag.
    assign write_d = (state_q == B_IDLE) ? !buf_empty : (avm_waitrequest || buf_many);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= B_IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            be_q          <= 2'b00;
            write_q       <= 1'b0;
            wf_q          <= 1'b0;
            idle_q        <= 1'b1;
            pixel_count_q <= '0;
        end else begin
            wf_q   <= push;
            idle_q <= buf_empty_d && !write_d;
            case (state_q)
                B_IDLE: begin
                    if (!buf_empty) begin
                        {addr_q, data_q} <= head_w;
                        write_q          <= 1'b1;
                        be_q             <= 2'b11;
                        state_q          <= B_WRITE;
                    end
                end
                B_WRITE: begin
                    if (!avm_waitrequest) begin
                        pixel_count_q <= pixel_count_q + 32'd1;
                        if (buf_many) begin
                            // Stream the next entry without an idle cycle.
                            {addr_q, data_q} <= next_w;
                        end else begin
                            write_q <= 1'b0;
                            be_q    <= 2'b00;
                            state_q <= B_IDLE;
                        end
                    end
                end
                default: state_q <= B_IDLE;
            endcase
        end
    end

    assign Write_Finish   = wf_q;
    assign avm_address    = addr_q;
    assign avm_write      = write_q;
    assign avm_writedata  = data_q;
    assign avm_byteenable = be_q;
    assign Idle           = idle_q;
    assign Pixel_Count    = pixel_count_q;

endmodule

// File: tb/tb_tlda_pixel_writer.sv
module tb_tlda_pixel_writer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        Draw = 1'b0;
    logic [31:0] Pixel_Address = '0;
    logic [15:0] Color = '0;
    logic        avm_waitrequest = 1'b0;
    logic        Write_Finish, avm_write, Idle;
    logic [31:0] avm_address, Pixel_Count;
    logic [15:0] avm_writedata;
    logic [1:0]  avm_byteenable;

    tlda_pixel_writer #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .Draw(Draw), .Pixel_Address(Pixel_Address),
        .Color(Color), .Write_Finish(Write_Finish), .avm_address(avm_address),
        .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
        .Idle(Idle), .Pixel_Count(Pixel_Count)
    );

    always #5 clk = ~clk;

`ifdef TLDA_PW_FIFO_EN
    localparam int EXP_HELD = 5;
    localparam int EXP_BP   = 4;
`else
    localparam int EXP_HELD = 4;
    localparam int EXP_BP   = 1;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int wf_cnt  = 0;
    logic [31:0] exp_cnt = '0;
    logic [49:0] wq[$];
    int          wcyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: a write completes on the edge after a negedge where
    // avm_write=1 and avm_waitrequest=0.
    always @(negedge clk) begin
        if (resetn && avm_write && !avm_waitrequest) begin
            wq.push_back({avm_byteenable, avm_address, avm_writedata});
            wcyc.push_back(cyc);
        end
        if (Write_Finish) wf_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output bit tmo);
        int c;
        c = 0;
        while (!Idle && c < 50) begin
            tick();
            c++;
        end
        tmo = (c >= 50);
    endtask

    // Presents n pixels (base+2k, A000+k) with a 2-cycle drawer cadence;
    // the bus is stalled for the first 'stall' edges.
    task automatic drive_seq(input int n, input logic [31:0] base, input int stall,
                             output int pulses_stall, output int unstable, output bit tmo);
        int idx, c;
        idx = 0; c = 0; pulses_stall = 0; unstable = 0;
        avm_waitrequest = (stall > 0);
        Draw = 1'b1; Pixel_Address = base; Color = 16'hA000;
        while ((idx < n || !Idle) && c < 400) begin
            tick();
            c++;
            if (c <= stall && avm_write && (avm_address !== base || avm_writedata !== 16'hA000))
                unstable++;
            if (Write_Finish) begin
                if (c <= stall) pulses_stall++;
                idx++;
                if (idx < n) begin
                    Pixel_Address = base + 32'(2 * idx);
                    Color         = 16'(16'hA000 + idx);
                end else begin
                    Draw = 1'b0;
                end
            end
            if (c == stall) avm_waitrequest = 1'b0;
        end
        Draw = 1'b0;
        avm_waitrequest = 1'b0;
        tmo = (c >= 400);
    endtask

    task automatic send_one(input logic [31:0] a, input logic [15:0] d, output bit tmo);
        Draw = 1'b1; Pixel_Address = a; Color = d;
        tick();
        tick();
        Draw = 1'b0;
        wait_idle(tmo);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (Write_Finish !== 1'b0) begin n_fail++; $display("FAIL reset_wf: got %b want 0", Write_Finish); end
        n_tests++; if (avm_write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b want 0", avm_write); end
        n_tests++; if (avm_address !== 32'h0 || avm_writedata !== 16'h0) begin n_fail++; $display("FAIL reset_addr_data: got %h/%h want 0/0", avm_address, avm_writedata); end
        n_tests++; if (avm_byteenable !== 2'b00) begin n_fail++; $display("FAIL reset_be: got %b want 00", avm_byteenable); end
        n_tests++; if (Idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", Idle); end
        n_tests++; if (Pixel_Count !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %h want 0", Pixel_Count); end
        resetn = 1'b1;
        tick();
        exp_cnt = '0;
    endtask

    task automatic test_single;
        bit tmo;
        wq.delete(); wcyc.delete(); wf_cnt = 0; avm_waitrequest = 1'b0;
        Draw = 1'b1; Pixel_Address = 32'h09000000; Color = 16'hFFFF;
        tick();
        n_tests++; if (Write_Finish !== 1'b1) begin n_fail++; $display("FAIL single_wf_pulse: got %b want 1", Write_Finish); end
        n_tests++; if (avm_write !== 1'b0 || Idle !== 1'b0) begin n_fail++; $display("FAIL single_capture_state: got write=%b idle=%b want 0/0", avm_write, Idle); end
        tick();
        Draw = 1'b0;
        n_tests++; if (avm_write !== 1'b1 || avm_byteenable !== 2'b11) begin n_fail++; $display("FAIL single_write_latency: got write=%b be=%b want 1/11", avm_write, avm_byteenable); end
        n_tests++; if (avm_address !== 32'h09000000 || avm_writedata !== 16'hFFFF) begin n_fail++; $display("FAIL single_addr_data: got %h/%h want 09000000/ffff", avm_address, avm_writedata); end
        n_tests++; if (Write_Finish !== 1'b0) begin n_fail++; $display("FAIL single_wf_width: got %b want 0", Write_Finish); end
        tick();
        exp_cnt = exp_cnt + 32'd1;
        n_tests++; if (Idle !== 1'b1 || avm_write !== 1'b0 || avm_byteenable !== 2'b00) begin n_fail++; $display("FAIL single_done: got idle=%b write=%b be=%b want 1/0/00", Idle, avm_write, avm_byteenable); end
        n_tests++; if (Pixel_Count !== exp_cnt) begin n_fail++; $display("FAIL single_count: got %0d want %0d", Pixel_Count, exp_cnt); end
        wait_idle(tmo);
        n_tests++; if (wf_cnt !== 1 || wq.size() !== 1) begin n_fail++; $display("FAIL single_totals: got pulses=%0d writes=%0d want 1/1", wf_cnt, wq.size()); end
    endtask

    task automatic test_held_draw;
        bit tmo;
        wq.delete(); wcyc.delete(); wf_cnt = 0; avm_waitrequest = 1'b0;
        Draw = 1'b1; Pixel_Address = 32'h09000100; Color = 16'h1234;
        repeat (10) tick();
        Draw = 1'b0;
        wait_idle(tmo);
        tick();
        exp_cnt = exp_cnt + 32'(EXP_HELD);
        n_tests++; if (tmo) begin n_fail++; $display("FAIL held_timeout: got busy want idle"); end
        n_tests++; if (wf_cnt !== EXP_HELD) begin n_fail++; $display("FAIL held_pulses: got %0d want %0d", wf_cnt, EXP_HELD); end
        n_tests++; if (wq.size() !== EXP_HELD) begin n_fail++; $display("FAIL held_writes: got %0d want %0d", wq.size(), EXP_HELD); end
        for (int k = 0; k < wq.size(); k++) begin
            n_tests++; if (wq[k] !== {2'b11, 32'h09000100, 16'h1234}) begin n_fail++; $display("FAIL held_entry%0d: got %h want 3_09000100_1234", k, wq[k]); end
        end
        n_tests++; if (Pixel_Count !== exp_cnt) begin n_fail++; $display("FAIL held_count: got %0d want %0d", Pixel_Count, exp_cnt); end
    endtask

    task automatic test_backpressure;
        int p, u;
        bit tmo;
        wq.delete(); wcyc.delete(); wf_cnt = 0;
        drive_seq(6, 32'h09001000, 20, p, u, tmo);
        exp_cnt = exp_cnt + 32'd6;
        n_tests++; if (tmo) begin n_fail++; $display("FAIL bp_timeout: got busy want done"); end
        n_tests++; if (p !== EXP_BP) begin n_fail++; $display("FAIL bp_pulses_in_stall: got %0d want %0d", p, EXP_BP); end
        n_tests++; if (u !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", u); end
        n_tests++; if (wq.size() !== 6) begin n_fail++; $display("FAIL bp_writes: got %0d want 6", wq.size()); end
        for (int k = 0; k < 6 && k < wq.size(); k++) begin
            n_tests++;
            if (wq[k] !== {2'b11, 32'h09001000 + 32'(2 * k), 16'(16'hA000 + k)}) begin
                n_fail++; $display("FAIL bp_order%0d: got %h want %h", k, wq[k], {2'b11, 32'h09001000 + 32'(2 * k), 16'(16'hA000 + k)});
            end
        end
`ifdef TLDA_PW_FIFO_EN
        // The four buffered pixels drain on consecutive edges.
        for (int k = 1; k < 4 && k < wcyc.size(); k++) begin
            n_tests++; if (wcyc[k] - wcyc[k-1] !== 1) begin n_fail++; $display("FAIL bp_back_to_back%0d: got gap %0d want 1", k, wcyc[k] - wcyc[k-1]); end
        end
`endif
        n_tests++; if (Pixel_Count !== exp_cnt) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", Pixel_Count, exp_cnt); end
    endtask

    task automatic test_back_to_back;
        int p, u;
        bit tmo;
        wq.delete(); wcyc.delete(); wf_cnt = 0;
        drive_seq(8, 32'h09000000, 0, p, u, tmo);
        exp_cnt = exp_cnt + 32'd8;
        n_tests++; if (tmo) begin n_fail++; $display("FAIL b2b_timeout: got busy want done"); end
        n_tests++; if (wq.size() !== 8 || wf_cnt !== 8) begin n_fail++; $display("FAIL b2b_totals: got writes=%0d pulses=%0d want 8/8", wq.size(), wf_cnt); end
        for (int k = 0; k < 8 && k < wq.size(); k++) begin
            n_tests++;
            if (wq[k] !== {2'b11, 32'h09000000 + 32'(2 * k), 16'(16'hA000 + k)}) begin
                n_fail++; $display("FAIL b2b_order%0d: got %h want %h", k, wq[k], {2'b11, 32'h09000000 + 32'(2 * k), 16'(16'hA000 + k)});
            end
        end
        n_tests++; if (Pixel_Count !== exp_cnt) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", Pixel_Count, exp_cnt); end
    endtask

    task automatic test_reset_mid;
        bit tmo;
        avm_waitrequest = 1'b1;
        Draw = 1'b1; Pixel_Address = 32'h09002000; Color = 16'h5555;
        tick();
        Pixel_Address = 32'h09002002; Color = 16'h6666;
        tick();
        tick();
        Draw = 1'b0;
        n_tests++; if (avm_write !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_write: got %b want 1", avm_write); end
        #2 resetn = 1'b0;
        #1;
        n_tests++; if (avm_write !== 1'b0 || Write_Finish !== 1'b0 || avm_byteenable !== 2'b00) begin n_fail++; $display("FAIL midrst_drop: got write=%b wf=%b be=%b want 0/0/00", avm_write, Write_Finish, avm_byteenable); end
        n_tests++; if (Pixel_Count !== 32'h0 || Idle !== 1'b1) begin n_fail++; $display("FAIL midrst_state: got count=%0d idle=%b want 0/1", Pixel_Count, Idle); end
        n_tests++; if (avm_address !== 32'h0) begin n_fail++; $display("FAIL midrst_addr: got %h want 0", avm_address); end
        avm_waitrequest = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        wq.delete(); wcyc.delete(); wf_cnt = 0;
        exp_cnt = 32'd1;
        send_one(32'h09003000, 16'h0F0F, tmo);
        tick();
        n_tests++; if (tmo || wq.size() !== 1) begin n_fail++; $display("FAIL midrst_after_writes: got %0d (tmo=%b) want 1", wq.size(), tmo); end
        n_tests++; if (wq.size() > 0 && wq[0] !== {2'b11, 32'h09003000, 16'h0F0F}) begin n_fail++; $display("FAIL midrst_after_entry: got %h want 3_09003000_0f0f", wq[0]); end
        n_tests++; if (Pixel_Count !== exp_cnt) begin n_fail++; $display("FAIL midrst_after_count: got %0d want %0d", Pixel_Count, exp_cnt); end
    endtask

    task automatic test_count_wrap;
        bit tmo;
        dut.pixel_count_q = 32'hFFFFFFFF;
        wq.delete(); wcyc.delete();
        send_one(32'h09004000, 16'h8001, tmo);
        n_tests++; if (tmo || wq.size() !== 1) begin n_fail++; $display("FAIL wrap_writes: got %0d (tmo=%b) want 1", wq.size(), tmo); end
        n_tests++; if (Pixel_Count !== 32'h0) begin n_fail++; $display("FAIL wrap_count: got %h want 00000000", Pixel_Count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_held_draw();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
